as608_packet_sequencer: RTL and testbench

Builds complete AS608 command packets from a compact command request and drives them byte-by-byte into the UART transmitter. It then parses the sensor's acknowledge packet from the UART receiver, checking header, PID and checksum, and enforcing a timeout. It returns the confirmation code and up to 4 data bytes in one response pulse. It sits between the fingerprint application FSM and the UART TX/RX pair, and is the only block that talks to the sensor link.

---
 rtl/as608_packet_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_as608_packet_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/as608_packet_sequencer.sv
// as608_packet_sequencer: builds AS608 command packets for the UART TX and parses the ack from UART RX.
// Optional macro AS608_RETRY_EN retransmits once on timeout or checksum error.
module as608_packet_sequencer #(
    parameter logic [31:0] DEV_ADDR    = 32'hFFFF_FFFF,
    parameter logic [23:0] TIMEOUT_CYC = 24'd5_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_code,
    input  logic [39:0] cmd_params,
    input  logic [2:0]  cmd_plen,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic        rsp_valid,
    output logic [7:0]  rsp_code,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_err
);
    typedef enum logic [3:0] {
        S_IDLE, S_TX_LOAD, S_TX_PULSE, S_TX_WAIT, S_RX_HDR, S_RX_LEN, S_RX_BODY, S_RX_SUM, S_RESP
    } state_t;

    state_t      r_state, w_state_n;
    logic [7:0]  r_code, r_lenh, r_sumh, r_rcode, r_rsp_code;
    logic [39:0] r_params;
    logic [2:0]  r_plen, r_ridx, r_blen;
    logic [4:0]  r_idx;
    logic [15:0] r_sum, r_rsum;
    logic [31:0] r_rdata, r_rsp_data;
    logic [23:0] r_to;
    logic [1:0]  r_rsp_err, w_err_n;
    logic [4:0]  w_ps, w_pend;
    logic [7:0]  w_tx_byte, w_pbyte, w_hexp;
    logic [15:0] w_rlen;
    logic        w_fin, w_retry_go, w_last, w_rx_st;
`ifdef AS608_RETRY_EN
    logic        r_retry;
`endif

    assign w_pend    = 5'(r_plen) + 5'd10;
    assign w_last    = r_idx == w_pend + 5'd1;
    assign w_ps      = 5'(r_plen) + 5'd9 - r_idx;
    assign w_pbyte   = 8'(r_params >> {w_ps, 3'b000});
    assign w_rlen    = {r_lenh, rx_data};
    assign w_rx_st   = r_state inside {S_RX_HDR, S_RX_LEN, S_RX_BODY, S_RX_SUM};
    assign cmd_ready = r_state == S_IDLE;
    assign tx_start  = r_state == S_TX_PULSE;
    assign tx_data   = tx_start ? w_tx_byte : 8'h00;
    assign rsp_valid = r_state == S_RESP;
    assign rsp_code  = r_rsp_code;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

    always_comb begin
        case (r_idx)
            5'd0:    w_tx_byte = 8'hEF;
            5'd1:    w_tx_byte = 8'h01;
            5'd2:    w_tx_byte = DEV_ADDR[31:24];
            5'd3:    w_tx_byte = DEV_ADDR[23:16];
            5'd4:    w_tx_byte = DEV_ADDR[15:8];
            5'd5:    w_tx_byte = DEV_ADDR[7:0];
            5'd6:    w_tx_byte = 8'h01;
            5'd7:    w_tx_byte = 8'h00;
            5'd8:    w_tx_byte = 8'(r_plen) + 8'd3;
            5'd9:    w_tx_byte = r_code;
            default: w_tx_byte = (r_idx < w_pend) ? w_pbyte : (r_idx == w_pend) ? r_sum[15:8] : r_sum[7:0];
        endcase
        case (r_ridx)
            3'd1:    w_hexp = 8'h01;
            3'd2:    w_hexp = DEV_ADDR[31:24];
            3'd3:    w_hexp = DEV_ADDR[23:16];
            3'd4:    w_hexp = DEV_ADDR[15:8];
            3'd5:    w_hexp = DEV_ADDR[7:0];
            default: w_hexp = 8'h07;
        endcase
    end

    always_comb begin
        w_state_n  = r_state;
        w_err_n    = 2'd0;
        w_fin      = 1'b0;
        w_retry_go = 1'b0;
        case (r_state)
            S_IDLE:     w_state_n = cmd_valid ? S_TX_LOAD : S_IDLE;
            S_TX_LOAD:  w_state_n = tx_busy ? S_TX_LOAD : S_TX_PULSE;
            S_TX_PULSE: w_state_n = S_TX_WAIT;
            S_TX_WAIT:  w_state_n = tx_busy ? S_TX_WAIT : w_last ? S_RX_HDR : S_TX_LOAD;
            S_RX_HDR: if (rx_done) begin
                if (r_ridx != 3'd0 && rx_data != w_hexp) begin
                    w_fin   = 1'b1;
                    w_err_n = 2'd2;
                end else if (r_ridx == 3'd6) w_state_n = S_RX_LEN;
            end
            S_RX_LEN: if (rx_done && r_ridx == 3'd1) begin
                if (w_rlen < 16'd3 || w_rlen > 16'd7) begin
                    w_fin   = 1'b1;
                    w_err_n = 2'd2;
                end else w_state_n = S_RX_BODY;
            end
            S_RX_BODY: if (rx_done && r_blen == 3'd1) w_state_n = S_RX_SUM;
            S_RX_SUM: if (rx_done && r_ridx == 3'd1) begin
                w_fin   = 1'b1;
                w_err_n = ({r_sumh, rx_data} == r_rsum) ? 2'd0 : 2'd3;
            end
            S_RESP:  w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
        // An arriving byte beats a simultaneous timeout expiry
        if (w_rx_st && !rx_done && r_to == TIMEOUT_CYC - 24'd1) begin
            w_fin   = 1'b1;
            w_err_n = 2'd1;
        end
        if (w_fin) w_state_n = S_RESP;
`ifdef AS608_RETRY_EN
        if (w_fin && !r_retry && w_err_n[0]) begin
            w_retry_go = 1'b1;
            w_state_n  = S_TX_LOAD;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_code     <= 8'd0;
            r_params   <= 40'd0;
            r_plen     <= 3'd0;
            r_idx      <= 5'd0;
            r_sum      <= 16'd0;
            r_ridx     <= 3'd0;
            r_blen     <= 3'd0;
            r_lenh     <= 8'd0;
            r_sumh     <= 8'd0;
            r_rsum     <= 16'd0;
            r_rcode    <= 8'd0;
            r_rdata    <= 32'd0;
            r_to       <= 24'd0;
            r_rsp_code <= 8'd0;
            r_rsp_data <= 32'd0;
            r_rsp_err  <= 2'd0;
`ifdef AS608_RETRY_EN
            r_retry    <= 1'b0;
`endif
        end else begin
            r_state <= w_state_n;
            if (r_state == S_IDLE && cmd_valid) begin
                r_code     <= cmd_code;
                r_params   <= cmd_params;
                r_plen     <= (cmd_plen > 3'd5) ? 3'd5 : cmd_plen;
                r_idx      <= 5'd0;
                r_sum      <= 16'd0;
                r_rsp_code <= 8'd0;
                r_rsp_data <= 32'd0;
                r_rsp_err  <= 2'd0;
`ifdef AS608_RETRY_EN
                r_retry    <= 1'b0;
`endif
            end
            if (r_state == S_TX_PULSE && r_idx >= 5'd6 && r_idx < w_pend) r_sum <= r_sum + 16'(w_tx_byte);
            if (r_state == S_TX_WAIT && !tx_busy && !w_last) r_idx <= r_idx + 5'd1;
            if (w_state_n == S_RX_HDR && r_state != S_RX_HDR) begin
                r_ridx  <= 3'd0;
                r_to    <= 24'd0;
                r_rsum  <= 16'h0007;
                r_rcode <= 8'd0;
                r_rdata <= 32'd0;
            end else if (w_rx_st) r_to <= rx_done ? 24'd0 : r_to + 24'd1;
            if (rx_done) begin
                case (r_state)
                    S_RX_HDR: r_ridx <= (r_ridx == 3'd6 || (r_ridx == 3'd0 && rx_data != 8'hEF)) ? 3'd0 : r_ridx + 3'd1;
                    S_RX_LEN: begin
                        r_rsum <= r_rsum + 16'(rx_data);
                        r_lenh <= rx_data;
                        r_blen <= 3'(rx_data - 8'd2);
                        r_ridx <= r_ridx ^ 3'd1;
                    end
                    S_RX_BODY: begin
                        r_rsum <= r_rsum + 16'(rx_data);
                        r_blen <= r_blen - 3'd1;
                        r_ridx <= (r_blen == 3'd1) ? 3'd0 : 3'd1;
                        if (r_ridx == 3'd0) r_rcode <= rx_data;
                        else r_rdata <= {r_rdata[23:0], rx_data};
                    end
                    S_RX_SUM: begin
                        r_sumh <= rx_data;
                        r_ridx <= 3'd1;
                    end
                    default: ;
                endcase
            end
            if (w_fin && !w_retry_go) begin
                r_rsp_err  <= w_err_n;
                r_rsp_code <= (w_err_n != 2'd0) ? 8'hFF : r_rcode;
                r_rsp_data <= (w_err_n != 2'd0) ? 32'd0 : r_rdata;
            end
            if (w_retry_go) begin
                r_idx <= 5'd0;
                r_sum <= 16'd0;
`ifdef AS608_RETRY_EN
                r_retry <= 1'b1;
`endif
            end
        end
    end
endmodule

// File: tb/tb_as608_packet_sequencer.sv
// tb_as608_packet_sequencer: scoreboard bench; expected TX bytes and responses are queued as stimulus is driven.
module tb_as608_packet_sequencer;
    localparam logic [23:0] TO = 24'd100;

    logic        clk = 1'b0, rst = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, tx_start, tx_busy, rx_done = 1'b0, rsp_valid;
    logic [7:0]  cmd_code = 8'd0, tx_data, rx_data = 8'd0, rsp_code;
    logic [39:0] cmd_params = 40'd0;
    logic [2:0]  cmd_plen = 3'd0;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_err;
    logic [2:0]  bcnt;

    int total = 0, bad = 0, cyc = 0, tx_cnt = 0, rsp_cnt = 0, t_last = 0, t_rsp = 0;
    logic [7:0]  exp_tx[$];
    logic [7:0]  rxq[$];
    logic [41:0] exp_rsp[$];

    as608_packet_sequencer #(.DEV_ADDR(32'hFFFF_FFFF), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
        .cmd_params(cmd_params), .cmd_plen(cmd_plen), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .rx_data(rx_data), .rx_done(rx_done), .rsp_valid(rsp_valid),
        .rsp_code(rsp_code), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // UART TX model: busy for four cycles after each start pulse
    assign tx_busy = bcnt != 3'd0;
    always @(posedge clk or negedge rst)
        if (!rst) bcnt <= 3'd0;
        else if (tx_start) bcnt <= 3'd4;
        else if (bcnt != 3'd0) bcnt <= bcnt - 3'd1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (tx_start) begin
            tx_cnt++;
            t_last = cyc;
            if (exp_tx.size() == 0) chk("tx_unexpected", 32'(tx_start), 32'd0);
            else chk("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
        end
        if (rsp_valid) begin
            logic [41:0] e;
            rsp_cnt++;
            t_rsp = cyc;
            if (exp_rsp.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            else begin
                e = exp_rsp.pop_front();
                chk("rsp_code", 32'(rsp_code), 32'(e[41:34]));
                chk("rsp_data", rsp_data, e[33:2]);
                chk("rsp_err", 32'(rsp_err), 32'(e[1:0]));
            end
        end
    end

    task automatic exp_pkt(input logic [7:0] code, input logic [39:0] prm, input logic [2:0] plen);
        int p;
        logic [15:0] s;
        logic [7:0] b;
        p = (plen > 3'd5) ? 5 : int'(plen);
        s = 16'(1 + p + 3) + 16'(code);
        exp_tx.push_back(8'hEF); exp_tx.push_back(8'h01);
        repeat (4) exp_tx.push_back(8'hFF);
        exp_tx.push_back(8'h01); exp_tx.push_back(8'h00); exp_tx.push_back(8'(p + 3)); exp_tx.push_back(code);
        for (int i = p - 1; i >= 0; i--) begin
            b = prm[8*i +: 8];
            s = s + 16'(b);
            exp_tx.push_back(b);
        end
        exp_tx.push_back(s[15:8]); exp_tx.push_back(s[7:0]);
    endtask

    task automatic mk_ack(input logic [7:0] code, input int nd, input logic [31:0] d, input logic [15:0] adj);
        logic [15:0] s;
        logic [7:0] b;
        s = 16'(7 + nd + 3) + 16'(code);
        rxq.push_back(8'hEF); rxq.push_back(8'h01);
        repeat (4) rxq.push_back(8'hFF);
        rxq.push_back(8'h07); rxq.push_back(8'h00); rxq.push_back(8'(nd + 3)); rxq.push_back(code);
        for (int i = nd - 1; i >= 0; i--) begin
            b = d[8*i +: 8];
            s = s + 16'(b);
            rxq.push_back(b);
        end
        s = s + adj;
        rxq.push_back(s[15:8]); rxq.push_back(s[7:0]);
    endtask

    task automatic send_rx();
        while (rxq.size() != 0) begin
            @(negedge clk);
            rx_data = rxq.pop_front();
            rx_done = 1'b1;
            @(negedge clk);
            rx_done = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic issue(input logic [7:0] code, input logic [39:0] prm, input logic [2:0] plen);
        exp_pkt(code, prm, plen);
        @(negedge clk);
        cmd_code = code; cmd_params = prm; cmd_plen = plen; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_tx();
        bit ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            ok = exp_tx.size() == 0 && !tx_busy;
        end
        if (!ok) chk("tx_wait", 32'(exp_tx.size()), 32'd0);
        repeat (10) @(negedge clk);
    endtask

    task automatic wait_rsp(input int n);
        bit ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            ok = rsp_cnt > n;
        end
        if (!ok) chk("rsp_wait", 32'(rsp_cnt), 32'(n + 1));
    endtask

    task automatic push_rsp(input logic [7:0] c, input logic [31:0] d, input logic [1:0] e);
        exp_rsp.push_back({c, d, e});
    endtask

    initial begin
        int n, base, lat;
        bit hit;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_txstart", 32'(tx_start), 32'd0);
        chk("rst_rspvalid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp", {rsp_code, rsp_data[21:0], rsp_err}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // GenImg
        n = rsp_cnt; issue(8'h01, 40'd0, 3'd0); wait_tx();
        push_rsp(8'h00, 32'd0, 2'd0); mk_ack(8'h00, 0, 32'd0, 16'd0); send_rx(); wait_rsp(n);

        // Search with 5 params and 4 data bytes
        n = rsp_cnt; issue(8'h04, 40'h01_0000_00A3, 3'd5); wait_tx();
        push_rsp(8'h00, 32'h0005_0040, 2'd0); mk_ack(8'h00, 4, 32'h0005_0040, 16'd0); send_rx(); wait_rsp(n);

        // Checksum off by one
        n = rsp_cnt; issue(8'h01, 40'd0, 3'd0); wait_tx();
        mk_ack(8'h00, 0, 32'd0, 16'd1);
`ifdef AS608_RETRY_EN
        send_rx(); exp_pkt(8'h01, 40'd0, 3'd0); wait_tx();
        push_rsp(8'h00, 32'd0, 2'd0); mk_ack(8'h00, 0, 32'd0, 16'd0);
`else
        push_rsp(8'hFF, 32'd0, 2'd3);
`endif
        send_rx(); wait_rsp(n);

        // Silent link
        n = rsp_cnt; issue(8'h01, 40'd0, 3'd0);
`ifdef AS608_RETRY_EN
        exp_pkt(8'h01, 40'd0, 3'd0);
`endif
        push_rsp(8'hFF, 32'd0, 2'd1); wait_rsp(n);
        lat = t_rsp - t_last;
        chk("to_lat_min", 32'(lat >= 100), 32'd1);
        chk("to_lat_max", 32'(lat <= 110), 32'd1);

        // Junk ahead of the header, clamped plen 7 -> 5
        n = rsp_cnt; issue(8'h02, 40'h11_2233_4455, 3'd7); wait_tx();
        rxq.push_back(8'h55); rxq.push_back(8'h13);
        push_rsp(8'h0A, 32'h0000_00C3, 2'd0); mk_ack(8'h0A, 1, 32'hC3, 16'd0); send_rx(); wait_rsp(n);

        // Wrong PID
        n = rsp_cnt; issue(8'h01, 40'd0, 3'd0); wait_tx();
        rxq = '{8'hEF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
        push_rsp(8'hFF, 32'd0, 2'd2); send_rx(); wait_rsp(n);
        repeat (5) @(negedge clk);
        chk("hold_err", 32'(rsp_err), 32'd2);
        chk("hold_code", 32'(rsp_code), 32'hFF);

        // Length 8 is out of range
        n = rsp_cnt; issue(8'h01, 40'd0, 3'd0); wait_tx();
        rxq = '{8'hEF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h07, 8'h00, 8'h08};
        push_rsp(8'hFF, 32'd0, 2'd2); send_rx(); wait_rsp(n);

        // Reset during the 5th TX byte
        issue(8'h01, 40'd0, 3'd0);
        base = tx_cnt; hit = 0;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(posedge clk); #1;
            hit = tx_start && tx_cnt == base + 4;
        end
        chk("rst_hit", 32'(hit), 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst_txstart", 32'(tx_start), 32'd0);
        exp_tx.delete();
        n = rsp_cnt;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        chk("midrst_ready", 32'(cmd_ready), 32'd1);
        chk("midrst_no_rsp", 32'(rsp_cnt), 32'(n));

        n = rsp_cnt; issue(8'h01, 40'd0, 3'd0); wait_tx();
        push_rsp(8'h00, 32'd0, 2'd0); mk_ack(8'h00, 0, 32'd0, 16'd0); send_rx(); wait_rsp(n);
        repeat (5) @(negedge clk);
        chk("left_tx", 32'(exp_tx.size()), 32'd0);
        chk("left_rsp", 32'(exp_rsp.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
